// File: rtl/rd_empty.sv
// Read-side pointer and empty-flag controller of the async FIFO.
// Holds the binary/Gray read pointer, RAM read address, fill level, almost-empty and sticky underflow.
module rd_empty #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                          r_clk,
   input  logic                          rst_n,
   input  logic                          rd_rq,
   input  logic [$clog2(DEPTH):0]        rsync_ptr2,
   output logic [$clog2(DEPTH)-1:0]      raddr,
   output logic [$clog2(DEPTH):0]        rptr,
   output logic                          empty,
   output logic                          almost_empty,
   output logic [$clog2(DEPTH):0]        rlevel,
   output logic                          underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic          rd_acc;
   logic [PW-1:0] wbin;
   logic [PW-1:0] rbin_d,  rbin_q;
   logic [PW-1:0] rptr_d,  rptr_q;
   logic [PW-1:0] rlevel_d, rlevel_q;
   logic          empty_d, empty_q;
   logic          almost_empty_d, almost_empty_q;
   logic          underflow_d, underflow_q;

   // Next pointer, Gray conversion of both pointers and level/flag computation
   always_comb begin
      rd_acc = rd_rq & ~empty_q;
      rbin_d = rbin_q + {{AW{1'b0}}, rd_acc};
      rptr_d = (rbin_d >> 1) ^ rbin_d;

      wbin = rsync_ptr2;
      for (int i = int'(AW) - 1; i >= 0; i--) begin
         wbin[i] = wbin[i+1] ^ rsync_ptr2[i];
      end

      rlevel_d       = wbin - rbin_d;
      empty_d        = (rptr_d == rsync_ptr2);
      almost_empty_d = (rlevel_d <= PW'(AE_THRESH));
      underflow_d    = underflow_q | (rd_rq & empty_q);
   end

   // State and output registers; reset is synchronous and active-high
   always_ff @(posedge r_clk) begin
      if (rst_n) begin
         rbin_q         <= '0;
         rptr_q         <= '0;
         rlevel_q       <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         underflow_q    <= 1'b0;
      end else begin
         rbin_q         <= rbin_d;
         rptr_q         <= rptr_d;
         rlevel_q       <= rlevel_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         underflow_q    <= underflow_d;
      end
   end

   assign raddr        = rbin_q[AW-1:0];
   assign rptr         = rptr_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign rlevel       = rlevel_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_empty.sv
// Randomised and directed bench for rd_empty against a count-based reference model.
module tb_rd_empty;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AE    = 2;
   localparam int unsigned AW    = 4;
   localparam int unsigned PW    = 5;

   logic          r_clk = 1'b0;
   logic          rst_n;
   logic          rd_rq;
   logic [PW-1:0] rsync_ptr2;
   logic [AW-1:0] raddr;
   logic [PW-1:0] rptr;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rlevel;
   logic          underflow;

   rd_empty #(.DEPTH(DEPTH), .AE_THRESH(AE)) dut (
      .r_clk(r_clk), .rst_n(rst_n), .rd_rq(rd_rq), .rsync_ptr2(rsync_ptr2),
      .raddr(raddr), .rptr(rptr), .empty(empty), .almost_empty(almost_empty),
      .rlevel(rlevel), .underflow(underflow)
   );

   always #5 r_clk = ~r_clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: total words written and read as plain counters
   int   wcnt = 0;
   int   m_rd = 0;
   logic m_empty = 1'b1, m_ae = 1'b1, m_uf = 1'b0;
   int   m_level = 0;
   logic [PW-1:0] prev_rptr = '0;
   logic          prev_ok = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] to_gray(input int v);
      logic [PW-1:0] b;
      b = PW'(v);
      return b ^ (b >> 1);
   endfunction

   // One clock: drive inputs, advance model, sample outputs 1ns after the edge
   task automatic step(input logic rst, input logic rq);
      int lv;
      rst_n      = rst;
      rd_rq      = rq;
      rsync_ptr2 = to_gray(wcnt);
      if (rst) begin
         m_rd = 0; m_empty = 1'b1; m_ae = 1'b1; m_level = 0; m_uf = 1'b0;
      end else begin
         m_uf = m_uf | (rq & m_empty);
         if (rq && !m_empty) m_rd++;
         lv      = (wcnt - m_rd) & ((2 * DEPTH) - 1);
         m_level = lv;
         m_empty = (lv == 0);
         m_ae    = (lv <= int'(AE));
      end
      @(posedge r_clk);
      #1;
      chk("empty",        32'(empty),        32'(m_empty));
      chk("almost_empty", 32'(almost_empty), 32'(m_ae));
      chk("rlevel",       32'(rlevel),       32'(m_level));
      chk("underflow",    32'(underflow),    32'(m_uf));
      chk("raddr",        32'(raddr),        32'(m_rd % DEPTH));
      chk("rptr",         32'(rptr),         32'(to_gray(m_rd)));
      if (!rst && prev_ok)
         chk("gray_step", 32'($countones(prev_rptr ^ rptr) <= 1), 32'd1);
      prev_rptr = rptr;
      prev_ok   = !rst;
   endtask

   int  wraps;
   logic [PW-1:0] last_rptr;

   initial begin
      rst_n = 1'b1; rd_rq = 1'b0; rsync_ptr2 = '0;

      // Reset with active request and nonzero write pointer
      wcnt = 3;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_rptr",  32'(rptr),  32'd0);

      // Fill to 3 then drain
      step(1'b0, 1'b0);
      chk("fill_level", 32'(rlevel), 32'd3);
      chk("fill_empty", 32'(empty),  32'd0);
      step(1'b0, 1'b1);
      chk("rd1_rptr", 32'(rptr), 32'b00001);
      step(1'b0, 1'b1);
      chk("rd2_rptr", 32'(rptr), 32'b00011);
      step(1'b0, 1'b1);
      chk("rd3_rptr",  32'(rptr),         32'b00010);
      chk("rd3_empty", 32'(empty),        32'd1);
      chk("rd3_ae",    32'(almost_empty), 32'd1);

      // Underflow is sticky until reset
      step(1'b0, 1'b1);
      chk("uf_set",   32'(underflow), 32'd1);
      chk("uf_raddr", 32'(raddr),     32'd3);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      chk("uf_hold", 32'(underflow), 32'd1);
      wcnt = 0;
      step(1'b1, 1'b0);
      chk("uf_clr", 32'(underflow), 32'd0);

      // Full level
      wcnt = 16;
      step(1'b0, 1'b0);
      chk("full_level", 32'(rlevel),       32'd16);
      chk("full_ae",    32'(almost_empty), 32'd0);
      wcnt = 0;
      step(1'b1, 1'b0);

      // Random stream with a writer that stays at most DEPTH ahead
      wraps = 0;
      last_rptr = rptr;
      for (int c = 0; c < 300; c++) begin
         if ((wcnt - m_rd) < int'(DEPTH) && $urandom_range(0, 3) != 0) wcnt++;
         step(1'b0, $urandom_range(0, 4) != 0);
         if (last_rptr == 5'b10000 && rptr == 5'b00000) wraps++;
         last_rptr = rptr;
      end
      chk("wrap_seen", 32'(wraps > 0), 32'd1);

      // Drain, then read the last word while the writer advances
      for (int i = 0; i < 40 && !m_empty; i++) step(1'b0, 1'b1);
      chk("drained", 32'(empty), 32'd1);
      wcnt++;
      step(1'b0, 1'b0);
      chk("lvl1", 32'(rlevel), 32'd1);
      wcnt++;
      step(1'b0, 1'b1);
      chk("simul_empty", 32'(empty),  32'd0);
      chk("simul_level", 32'(rlevel), 32'd1);

      // Reset in the middle of a read burst
      wcnt = wcnt + 5;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      wcnt = 0;
      step(1'b1, 1'b1);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_raddr", 32'(raddr), 32'd0);
      chk("mid_rst_level", 32'(rlevel), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
